// File: rtl/pipe_issue_arbiter_pkg.sv
// Shared opcode constants and drain FSM encoding for the ADD/SET/NAND pipeline issue path.
// Pure declarations: no latency, no flow control.
package pipe_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } drain_state_e;

    function automatic logic is_nop(input logic [7:0] inst);
        return inst[7:6] == OP_NOP;
    endfunction

endpackage

// File: rtl/pipe_issue_arbiter_if.sv
// Bundle of the two source handshakes, the pipeline issue port and drain/status signals.
// slave is the arbiter's view; master is the view of whatever drives the sources and pipeline.
interface pipe_issue_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       s0_inst;
    logic             s0_valid;
    logic             s0_ready;
    logic [7:0]       s1_inst;
    logic             s1_valid;
    logic             s1_ready;
    logic [7:0]       pipe_inst;
    logic             pipe_inst_valid;
    logic             pipe_inst_ready;
    logic             pipe_id_ex_valid;
    logic             pipe_ex_wb_valid;
    logic             drain_req;
    logic             drained;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  s0_inst, s0_valid, s1_inst, s1_valid,
        input  pipe_inst_ready, pipe_id_ex_valid, pipe_ex_wb_valid, drain_req,
        output s0_ready, s1_ready, pipe_inst, pipe_inst_valid, drained, cnt0, cnt1
    );

    modport master (
        output s0_inst, s0_valid, s1_inst, s1_valid,
        output pipe_inst_ready, pipe_id_ex_valid, pipe_ex_wb_valid, drain_req,
        input  s0_ready, s1_ready, pipe_inst, pipe_inst_valid, drained, cnt0, cnt1
    );

endinterface

// File: rtl/pipe_issue_arbiter_rr_arb2.sv
// Two-way round-robin grant; combinational grant, last_grant moves only when advance is high.
// No backpressure of its own: the caller decides when a grant is consumed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

    logic last_grant;

    always_comb begin
        grant = ~last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last_grant;
        endcase
    end

    // Reset to 1 so that source 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue of two sources into one registered pipeline port, with NOP drop and drain.
// Latency 1 cycle source->pipe_inst_valid; sources stall while the output is held or draining.
module pipe_issue_arbiter
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DROP_NOP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_issue_arbiter_if.slave   bus
);

    drain_state_e     state;
    drain_state_e     state_nx;
    logic             load_en;
    logic             accept_ok;
    logic             grant;
    logic             xfer;
    logic             fwd;
    logic [7:0]       sel_inst;
    logic [7:0]       inst_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    logic             pipe_empty;

    assign load_en   = !vld_q || bus.pipe_inst_ready;
    // drain_req gates acceptance directly so nothing slips in on the cycle it rises.
    assign accept_ok = rst && (state == ST_RUN) && !bus.drain_req && load_en;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.s1_valid, bus.s0_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    assign bus.s0_ready = accept_ok && !grant;
    assign bus.s1_ready = accept_ok &&  grant;

    assign xfer     = (bus.s0_valid && bus.s0_ready) || (bus.s1_valid && bus.s1_ready);
    assign sel_inst = grant ? bus.s1_inst : bus.s0_inst;
    assign fwd      = xfer && !((DROP_NOP != 0) && is_nop(sel_inst));

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_q <= 8'h00;
            vld_q  <= 1'b0;
        end else if (fwd) begin
            inst_q <= sel_inst;
            vld_q  <= 1'b1;
        end else if (bus.pipe_inst_ready) begin
            vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (fwd) begin
            if (grant) begin
                cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pipe_empty = !vld_q && !bus.pipe_id_ex_valid && !bus.pipe_ex_wb_valid;

    // A request withdrawn in DRAIN returns to RUN even if the pipe happens to be empty that cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (bus.drain_req) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.drain_req)  state_nx = ST_RUN;
                else if (pipe_empty) state_nx = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!bus.drain_req) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    assign bus.pipe_inst       = inst_q;
    assign bus.pipe_inst_valid = vld_q;
    assign bus.drained         = (state == ST_DRAINED);
    assign bus.cnt0            = cnt0_q;
    assign bus.cnt1            = cnt1_q;

endmodule
